// File: rtl/mem_addr_mux_nch.sv
// mem_addr_mux_nch: clocked N-source dual-rail address mux.
// Every input passes through a synchroniser. A DATA or NULL wavefront must then
// hold steady for STABLE_CYC samples before it is registered, and a four-phase
// ack handshake runs with the downstream stage. Encoding faults set a sticky flag.
module mem_addr_mux_nch #(
  parameter int ADDR_BITS   = 4,
  parameter int N_SRC       = 2,
  parameter int SEL_BITS    = 1,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2,
  parameter int CNT_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*SEL_BITS-1:0]        sel,
  input  logic [N_SRC*2*ADDR_BITS-1:0] addr_in,
  input  logic                         ack_next,
  output logic [2*ADDR_BITS-1:0]       addr_out,
  output logic                         ack,
  output logic                         err,
  input  logic                         err_clr,
  output logic [CNT_W-1:0]             xfer_cnt
);

  localparam int AW = 2*ADDR_BITS;
  localparam int SW = 2*SEL_BITS;
  localparam int QW = $clog2(STABLE_CYC+1);
  localparam logic [SEL_BITS:0] N_SRC_L = (SEL_BITS+1)'(N_SRC);
  localparam logic [QW-1:0]     Q_ONE   = QW'(1);
  localparam logic [QW-1:0]     Q_MAX   = QW'(STABLE_CYC);
  localparam bit                SINGLE  = (STABLE_CYC == 1);

  typedef enum logic [1:0] {NULL_WAIT, DATA_QUAL, DATA_HOLD, NULL_QUAL} state_t;

  state_t state;

  logic [SYNC_STAGES-1:0][SW-1:0]       sel_sync;
  logic [SYNC_STAGES-1:0][N_SRC*AW-1:0] addr_sync;
  logic [SYNC_STAGES-1:0]               ackn_sync;

  logic [SW-1:0]       s_sel;
  logic [N_SRC*AW-1:0] s_addr;
  logic                s_ackn;

  logic [SEL_BITS-1:0] idx, snap_idx, lidx;
  logic [AW-1:0]       snap_word, src_word, hold_word;
  logic [QW-1:0]       qcnt, cnt_inc;
  logic                sel_complete, sel_illegal, idx_in_range;
  logic                data_complete, null_complete, in_hold, err_event;

  // Select the word of source k; out-of-range indices read as NULL.
  function automatic logic [AW-1:0] pick(input logic [N_SRC*AW-1:0] bus,
                                         input logic [SEL_BITS-1:0] k);
    logic [AW-1:0] res;
    res = '0;
    for (int j = 0; j < N_SRC; j++)
      if ({1'b0, k} == (SEL_BITS+1)'(j)) res = bus[j*AW +: AW];
    return res;
  endfunction

  // A word is complete when every pair has exactly one rail high.
  function automatic logic word_complete(input logic [AW-1:0] w);
    logic res;
    res = 1'b1;
    for (int i = 0; i < ADDR_BITS; i++)
      if (w[2*i+1] == w[2*i]) res = 1'b0;
    return res;
  endfunction

  // A word is illegal when any pair has both rails high.
  function automatic logic word_illegal(input logic [AW-1:0] w);
    logic res;
    res = 1'b0;
    for (int i = 0; i < ADDR_BITS; i++)
      if (w[2*i+1] & w[2*i]) res = 1'b1;
    return res;
  endfunction

  // Shift every asynchronous input through its synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_sync  <= '0;
      addr_sync <= '0;
      ackn_sync <= '0;
    end else begin
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], sel};
      addr_sync <= {addr_sync[SYNC_STAGES-2:0], addr_in};
      ackn_sync <= {ackn_sync[SYNC_STAGES-2:0], ack_next};
    end
  end

  assign s_sel  = sel_sync[SYNC_STAGES-1];
  assign s_addr = addr_sync[SYNC_STAGES-1];
  assign s_ackn = ackn_sync[SYNC_STAGES-1];

  // Decode the synced select: completeness, illegality and the binary index.
  always_comb begin
    sel_complete = 1'b1;
    sel_illegal  = 1'b0;
    idx          = '0;
    for (int i = 0; i < SEL_BITS; i++) begin
      if (s_sel[2*i+1] == s_sel[2*i]) sel_complete = 1'b0;
      if (s_sel[2*i+1] & s_sel[2*i])  sel_illegal  = 1'b1;
      idx[i] = s_sel[2*i+1];
    end
  end

  assign idx_in_range  = ({1'b0, idx} < N_SRC_L);
  assign src_word      = pick(s_addr, idx);
  assign hold_word     = pick(s_addr, lidx);
  assign data_complete = sel_complete & idx_in_range & word_complete(src_word);
  assign null_complete = (s_sel == '0) & (hold_word == '0);
  assign in_hold       = (state == DATA_HOLD) || (state == NULL_QUAL);
  assign cnt_inc       = (qcnt == Q_MAX) ? qcnt : qcnt + Q_ONE;

  // While DATA is held, the latched source is the one monitored for faults.
  assign err_event = sel_illegal | (sel_complete & ~idx_in_range) |
                     (in_hold ? word_illegal(hold_word)
                              : (sel_complete & idx_in_range & word_illegal(src_word)));

  // Sticky error flag; a new fault wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err <= 1'b0;
    else if (err_event) err <= 1'b1;
    else if (err_clr)   err <= 1'b0;
  end

  // Handshake FSM: qualify DATA, hold it, qualify NULL, release and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= NULL_WAIT;
      addr_out  <= '0;
      ack       <= 1'b0;
      xfer_cnt  <= '0;
      qcnt      <= '0;
      snap_idx  <= '0;
      snap_word <= '0;
      lidx      <= '0;
    end else begin
      case (state)
        NULL_WAIT: begin
          if (data_complete) begin
            snap_idx  <= idx;
            snap_word <= src_word;
            qcnt      <= Q_ONE;
            if (SINGLE && !s_ackn) begin
              state    <= DATA_HOLD;
              addr_out <= src_word;
              ack      <= 1'b1;
              lidx     <= idx;
            end else begin
              state <= DATA_QUAL;
            end
          end
        end
        DATA_QUAL: begin
          if (err_event || !data_complete || idx != snap_idx || src_word != snap_word) begin
            state <= NULL_WAIT;
          end else begin
            qcnt <= cnt_inc;
            if (cnt_inc == Q_MAX && !s_ackn) begin
              state    <= DATA_HOLD;
              addr_out <= snap_word;
              ack      <= 1'b1;
              lidx     <= snap_idx;
            end
          end
        end
        DATA_HOLD: begin
          if (null_complete && s_ackn) begin
            qcnt <= Q_ONE;
            if (SINGLE) begin
              state    <= NULL_WAIT;
              addr_out <= '0;
              ack      <= 1'b0;
              xfer_cnt <= xfer_cnt + CNT_W'(1);
            end else begin
              state <= NULL_QUAL;
            end
          end
        end
        NULL_QUAL: begin
          if (!null_complete) begin
            state <= DATA_HOLD;
          end else begin
            qcnt <= cnt_inc;
            if (cnt_inc == Q_MAX) begin
              state    <= NULL_WAIT;
              addr_out <= '0;
              ack      <= 1'b0;
              xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= NULL_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_addr_mux_nch.sv
// tb_mem_addr_mux_nch: scoreboard bench for mem_addr_mux_nch.
// Each ack edge the design produces is matched against the next expected
// response queued by the stimulus; a second instance covers N_SRC=3.
module tb_mem_addr_mux_nch;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic [15:0] addr_in;
  logic        ack_next;
  logic [7:0]  addr_out;
  logic        ack;
  logic        err;
  logic        err_clr;
  logic [7:0]  xfer_cnt;

  logic [3:0]  sel3;
  logic [23:0] addr_in3;
  logic        ack_next3;
  logic [7:0]  addr_out3;
  logic        ack3;
  logic        err3;
  logic        err_clr3;
  logic [7:0]  xfer_cnt3;

  typedef struct {
    logic       ack;
    logic [7:0] addr;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   model_cnt = 0;
  bit   mon_en    = 1'b0;
  logic prev_ack  = 1'b0;

  mem_addr_mux_nch u_dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .addr_in(addr_in), .ack_next(ack_next),
    .addr_out(addr_out), .ack(ack), .err(err), .err_clr(err_clr), .xfer_cnt(xfer_cnt)
  );

  mem_addr_mux_nch #(.N_SRC(3), .SEL_BITS(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .addr_in(addr_in3), .ack_next(ack_next3),
    .addr_out(addr_out3), .ack(ack3), .err(err3), .err_clr(err_clr3), .xfer_cnt(xfer_cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logical 4-bit value to dual-rail: bit i -> {true, false} at [2i+1:2i].
  function automatic logic [7:0] encode4(input logic [3:0] v);
    logic [7:0] w;
    for (int i = 0; i < 4; i++) begin
      w[2*i+1] = v[i];
      w[2*i]   = ~v[i];
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [15:0] a, input logic an);
    sel      = s;
    addr_in  = a;
    ack_next = an;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitAck(input logic lvl, input int budget, input string name);
    int k;
    k = 0;
    while (ack !== lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ack !== lvl) begin
      errors++;
      $display("[TB] FAIL %s timeout actual=%0b expected=%0b", name, ack, lvl);
    end
  endtask

  task automatic pushExpect(input logic a, input logic [7:0] w, input int cnt);
    exp_t e;
    e.ack  = a;
    e.addr = w;
    e.cnt  = 8'(cnt % 256);
    exp_q.push_back(e);
  endtask

  // Release DATA: NULL everywhere with ack_next high until ack falls.
  task automatic returnToNull();
    model_cnt++;
    pushExpect(1'b0, 8'h00, model_cnt);
    applyStimulus(2'b00, 16'h0000, 1'b1);
    waitAck(1'b0, 20, "null_ack");
    ack_next = 1'b0;
  endtask

  // One full transfer; optional 1-cycle decoy word and optional ack_next stall.
  task automatic doTransfer(input int idx, input logic [3:0] val, input bit glitch, input bit stall);
    logic [7:0]  word, gword, other;
    logic [1:0]  s;
    logic [15:0] bus, gbus;
    word  = encode4(val);
    other = encode4(4'($urandom_range(0, 15)));
    gword = encode4(val ^ 4'($urandom_range(1, 15)));
    s     = (idx == 1) ? 2'b10 : 2'b01;
    bus   = (idx == 1) ? {word, other} : {other, word};
    gbus  = (idx == 1) ? {gword, other} : {other, gword};
    pushExpect(1'b1, word, model_cnt);
    if (glitch) begin
      applyStimulus(s, gbus, 1'b0);
      stepEdges(1);
    end
    applyStimulus(s, bus, stall);
    if (stall) begin
      stepEdges(int'($urandom_range(6, 10)));
      ack_next = 1'b0;
    end
    waitAck(1'b1, 20, "data_ack");
    returnToNull();
  endtask

  // Scoreboard monitor: every ack edge consumes one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_ack = 1'b0;
      end else if (ack !== prev_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_ack_edge actual=%0b expected=no_event", ack);
        end else begin
          e = exp_q.pop_front();
          checkOutput("mon_ack", 32'(ack), 32'(e.ack));
          checkOutput("mon_addr", 32'(addr_out), 32'(e.addr));
          checkOutput("mon_cnt", 32'(xfer_cnt), 32'(e.cnt));
        end
        prev_ack = ack;
      end
    end
  end

  // Safety net in case something stalls outside a bounded wait.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases, random traffic, reset in HOLD and counter wrap.
  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b00, 16'h0000, 1'b0);
    err_clr = 1'b0;
    sel3 = 4'b0000; addr_in3 = 24'h0; ack_next3 = 1'b0; err_clr3 = 1'b0;
    stepEdges(3);
    checkOutput("rst_addr", 32'(addr_out), 32'h0);
    checkOutput("rst_ack", 32'(ack), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    stepEdges(2);

    // Basic transfer with exact four-edge latency in both directions.
    pushExpect(1'b1, 8'b10011001, 0);
    applyStimulus(2'b10, {8'b10011001, encode4(4'h3)}, 1'b0);
    stepEdges(3);
    checkOutput("t1_ack_early", 32'(ack), 32'h0);
    stepEdges(1);
    checkOutput("t1_ack", 32'(ack), 32'h1);
    checkOutput("t1_addr", 32'(addr_out), 32'h99);
    model_cnt = 1;
    pushExpect(1'b0, 8'h00, 1);
    applyStimulus(2'b00, 16'h0000, 1'b1);
    stepEdges(3);
    checkOutput("t1_null_early", 32'(ack), 32'h1);
    stepEdges(1);
    checkOutput("t1_null_ack", 32'(ack), 32'h0);
    checkOutput("t1_cnt", 32'(xfer_cnt), 32'h1);
    ack_next = 1'b0;
    stepEdges(3);

    // Partial wavefront completing one cycle later.
    applyStimulus(2'b10, {8'b00001001, 8'h00}, 1'b0);
    stepEdges(1);
    pushExpect(1'b1, 8'b01101001, model_cnt);
    applyStimulus(2'b10, {8'b01101001, 8'h00}, 1'b0);
    stepEdges(3);
    checkOutput("t2_ack_early", 32'(ack), 32'h0);
    stepEdges(1);
    checkOutput("t2_ack", 32'(ack), 32'h1);
    returnToNull();

    // A rail dropping during qualification aborts the transfer.
    applyStimulus(2'b01, {8'h00, encode4(4'h3)}, 1'b0);
    stepEdges(1);
    applyStimulus(2'b01, {8'h00, encode4(4'h3) & 8'b11111101}, 1'b0);
    stepEdges(8);
    checkOutput("t2_abort_ack", 32'(ack), 32'h0);
    applyStimulus(2'b00, 16'h0000, 1'b0);
    stepEdges(4);

    // ack_next held high stalls acceptance until it drops.
    pushExpect(1'b1, encode4(4'hC), model_cnt);
    applyStimulus(2'b01, {8'h00, encode4(4'hC)}, 1'b1);
    stepEdges(10);
    checkOutput("t3_stall_ack", 32'(ack), 32'h0);
    ack_next = 1'b0;
    stepEdges(1);
    checkOutput("t3_release_early", 32'(ack), 32'h0);
    stepEdges(2);
    checkOutput("t3_release_ack", 32'(ack), 32'h1);
    returnToNull();

    // Illegal pair in the addressed source; clear loses to a live fault.
    applyStimulus(2'b10, {8'b10011101, 8'h00}, 1'b0);
    stepEdges(2);
    checkOutput("t4_err_early", 32'(err), 32'h0);
    stepEdges(1);
    checkOutput("t4_err_set", 32'(err), 32'h1);
    checkOutput("t4_ack", 32'(ack), 32'h0);
    err_clr = 1'b1;
    stepEdges(1);
    err_clr = 1'b0;
    checkOutput("t4_err_priority", 32'(err), 32'h1);
    applyStimulus(2'b00, 16'h0000, 1'b0);
    stepEdges(4);
    checkOutput("t4_err_sticky", 32'(err), 32'h1);
    err_clr = 1'b1;
    stepEdges(1);
    err_clr = 1'b0;
    checkOutput("t4_err_clear", 32'(err), 32'h0);

    // Three-source instance: out-of-range index, then source 2.
    sel3 = 4'b1010;
    addr_in3 = {encode4(4'h5), encode4(4'hA), encode4(4'h3)};
    stepEdges(3);
    checkOutput("t5_err_idx3", 32'(err3), 32'h1);
    stepEdges(5);
    checkOutput("t5_ack_idx3", 32'(ack3), 32'h0);
    checkOutput("t5_cnt_idx3", 32'(xfer_cnt3), 32'h0);
    sel3 = 4'b0000;
    stepEdges(3);
    err_clr3 = 1'b1;
    stepEdges(1);
    err_clr3 = 1'b0;
    checkOutput("t5_err_clear", 32'(err3), 32'h0);
    sel3 = 4'b1001;
    stepEdges(4);
    checkOutput("t5_ack_src2", 32'(ack3), 32'h1);
    checkOutput("t5_addr_src2", 32'(addr_out3), 32'(encode4(4'h5)));
    sel3 = 4'b0000;
    addr_in3 = 24'h0;
    ack_next3 = 1'b1;
    stepEdges(4);
    checkOutput("t5_null_ack", 32'(ack3), 32'h0);
    checkOutput("t5_cnt", 32'(xfer_cnt3), 32'h1);
    ack_next3 = 1'b0;

    // Randomised traffic with decoy words and downstream stalls.
    for (int t = 0; t < 40; t++)
      doTransfer(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));

    // Fault while holding DATA leaves outputs alone; async reset clears all.
    pushExpect(1'b1, encode4(4'h6), model_cnt);
    applyStimulus(2'b01, {8'h00, encode4(4'h6)}, 1'b0);
    waitAck(1'b1, 20, "t6_data_ack");
    applyStimulus(2'b01, {8'h00, 8'b01101011}, 1'b0);
    stepEdges(4);
    checkOutput("t6_hold_err", 32'(err), 32'h1);
    checkOutput("t6_hold_ack", 32'(ack), 32'h1);
    checkOutput("t6_hold_addr", 32'(addr_out), 32'(encode4(4'h6)));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_addr", 32'(addr_out), 32'h0);
    checkOutput("t6_rst_ack", 32'(ack), 32'h0);
    checkOutput("t6_rst_err", 32'(err), 32'h0);
    checkOutput("t6_rst_cnt", 32'(xfer_cnt), 32'h0);
    applyStimulus(2'b00, 16'h0000, 1'b0);
    exp_q.delete();
    model_cnt = 0;
    stepEdges(2);
    rst_n = 1'b1;
    stepEdges(2);

    // 256 transfers bring the counter back round to zero.
    for (int t = 0; t < 256; t++)
      doTransfer(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    stepEdges(2);
    checkOutput("wrap_cnt", 32'(xfer_cnt), 32'h0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
